// File: rtl/bram_row_loader_pkg.sv
// Shared types and width helpers for the row-buffer loader and Disp_Map_Calc.
package bram_row_loader_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DefVres   = 480;
  localparam int unsigned DefWindow = 7;

  // Output rows the calculator produces for a frame of vres rows.
  function automatic int unsigned calc_out_rows(input int unsigned vres,
                                                input int unsigned window);
    return vres - window + 1;
  endfunction

  localparam int unsigned OutRows = calc_out_rows(DefVres, DefWindow);

  // Bits needed to hold the values 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Bits needed to index n items (0..n-1), never less than one.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bram_row_loader_if.sv
// Pixel stream, BRAM write port and calculator handshake of the row loader.
interface bram_row_loader_if #(
  parameter int unsigned BRAM_DATA_WIDTH = 16,
  parameter int unsigned BRAM_ADDR_WIDTH = 13,
  parameter int unsigned BRAM_WE_WIDTH   = 1
);

  logic                       start_frame;
  logic [BRAM_DATA_WIDTH-1:0] pix_data;
  logic                       pix_valid;
  logic                       pix_ready;
  logic                       en;
  logic [BRAM_WE_WIDTH-1:0]   we;
  logic [BRAM_ADDR_WIDTH-1:0] addr;
  logic [BRAM_DATA_WIDTH-1:0] din;
  logic                       busy;
  logic                       go;
  logic                       finished_row;
  logic                       frame_done;

  modport master (
    output start_frame, pix_data, pix_valid, finished_row,
    input  pix_ready, en, we, addr, din, busy, go, frame_done
  );

  modport slave (
    input  start_frame, pix_data, pix_valid, finished_row,
    output pix_ready, en, we, addr, din, busy, go, frame_done
  );

endinterface

// File: rtl/bram_row_loader_row_slot_addr_gen.sv
// Column and circular row-slot counters; forms the BRAM address of the next pixel.
module bram_row_loader_row_slot_addr_gen
  import bram_row_loader_pkg::*;
#(
  parameter int unsigned HRES                = 640,
  parameter int unsigned NUM_OF_ROWS_IN_BRAM = 8,
  parameter int unsigned BRAM_ADDR_WIDTH     = 13
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_clear,
  input  logic                       i_advance,
  output logic [BRAM_ADDR_WIDTH-1:0] o_addr,
  output logic                       o_row_last
);

  localparam int unsigned ColW  = idx_width(HRES);
  localparam int unsigned SlotW = idx_width(NUM_OF_ROWS_IN_BRAM);
  localparam int unsigned FullW = SlotW + cnt_width(HRES);

  localparam logic [ColW-1:0]  ColLast  = ColW'(HRES - 1);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(NUM_OF_ROWS_IN_BRAM - 1);

  logic [ColW-1:0]  r_col;
  logic [SlotW-1:0] r_slot;
  logic [FullW-1:0] w_full;

  assign o_row_last = i_advance && (r_col == ColLast);

  // Full-width slot*HRES+col, then fitted to the BRAM address bus.
  assign w_full = FullW'(r_slot) * FullW'(HRES) + FullW'(r_col);
  assign o_addr = BRAM_ADDR_WIDTH'(w_full);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col  <= '0;
      r_slot <= '0;
    end else if (i_clear) begin
      r_col  <= '0;
      r_slot <= '0;
    end else if (i_advance) begin
      if (r_col == ColLast) begin
        r_col  <= '0;
        r_slot <= (r_slot == SlotLast) ? '0 : r_slot + SlotW'(1);
      end else begin
        r_col <= r_col + ColW'(1);
      end
    end
  end

endmodule

// File: rtl/bram_row_loader.sv
// Writes a raster pixel stream into a circular row buffer and paces Disp_Map_Calc.
module bram_row_loader
  import bram_row_loader_pkg::*;
#(
  parameter int unsigned NUM_OF_ROWS_IN_BRAM = 8,
  parameter int unsigned VRES                = 480,
  parameter int unsigned HRES                = 640,
  parameter int unsigned WINDOW              = 7,
  parameter int unsigned BRAM_DATA_WIDTH     = 16,
  parameter int unsigned BRAM_ADDR_WIDTH     = 13,
  parameter int unsigned BRAM_WE_WIDTH       = 1
) (
  input logic               clk,
  input logic               reset,
  bram_row_loader_if.slave  io_bus
);

  localparam int unsigned RowsOut = calc_out_rows(VRES, WINDOW);
  localparam int unsigned LoadW   = cnt_width(VRES);
  localparam int unsigned DoneW   = cnt_width(RowsOut);

  state_e r_state;
  state_e w_state_nxt;

  logic [LoadW-1:0]           r_rows_loaded;
  logic [DoneW-1:0]           r_rows_done;
  logic                       r_en;
  logic [BRAM_ADDR_WIDTH-1:0] r_addr;
  logic [BRAM_DATA_WIDTH-1:0] r_din;
  logic                       r_busy;
  logic                       r_go;

  logic                       w_active;
  logic                       w_load_ok;
  logic                       w_pix_ready;
  logic                       w_hs;
  logic                       w_fin_ok;
  logic                       w_clear;
  logic                       w_frame_done;
  logic                       w_row_last;
  logic [BRAM_ADDR_WIDTH-1:0] w_addr;

  assign w_active = (r_state == StPrime) || (r_state == StRun);

  // Row rows_done is still inside the window, so its slot must not be refilled yet.
  assign w_load_ok = (32'(r_rows_loaded) < 32'(r_rows_done) + WINDOW + 32'd1) &&
                     (32'(r_rows_loaded) < VRES);

  assign w_pix_ready = w_active && w_load_ok;
  assign w_hs        = io_bus.pix_valid && w_pix_ready;
  assign w_fin_ok    = (r_state == StRun) && io_bus.finished_row &&
                       (32'(r_rows_done) < RowsOut);

  bram_row_loader_row_slot_addr_gen #(
    .HRES                (HRES),
    .NUM_OF_ROWS_IN_BRAM (NUM_OF_ROWS_IN_BRAM),
    .BRAM_ADDR_WIDTH     (BRAM_ADDR_WIDTH)
  ) u_addr_gen (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_clear),
    .i_advance  (w_hs),
    .o_addr     (w_addr),
    .o_row_last (w_row_last)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_clear      = 1'b0;
    w_frame_done = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (io_bus.start_frame) begin
          w_state_nxt = StPrime;
          w_clear     = 1'b1;
        end
      end
      StPrime: begin
        if (32'(r_rows_loaded) >= WINDOW) w_state_nxt = StRun;
      end
      StRun: begin
        if (32'(r_rows_done) >= RowsOut) w_state_nxt = StDone;
      end
      StDone: begin
        w_frame_done = 1'b1;
        w_state_nxt  = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= StIdle;
      r_rows_loaded <= '0;
      r_rows_done   <= '0;
      r_en          <= 1'b0;
      r_addr        <= '0;
      r_din         <= '0;
      r_busy        <= 1'b0;
      r_go          <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clear) begin
        r_rows_loaded <= '0;
        r_rows_done   <= '0;
      end else begin
        // The row counts as loaded from the cycle its last write is on the port.
        if (w_row_last) r_rows_loaded <= r_rows_loaded + LoadW'(1);
        if (w_fin_ok)   r_rows_done   <= r_rows_done + DoneW'(1);
      end
      r_en <= w_hs;
      if (w_hs) begin
        r_addr <= w_addr;
        r_din  <= io_bus.pix_data;
      end
      r_busy <= w_active && (32'(r_rows_loaded) < 32'(r_rows_done) + WINDOW);
      r_go   <= (r_state == StPrime) && (w_state_nxt == StRun);
    end
  end

  assign io_bus.pix_ready  = w_pix_ready;
  assign io_bus.en         = r_en;
  assign io_bus.we         = {BRAM_WE_WIDTH{r_en}};
  assign io_bus.addr       = r_addr;
  assign io_bus.din        = r_din;
  assign io_bus.busy       = r_busy;
  assign io_bus.go         = r_go;
  assign io_bus.frame_done = w_frame_done;

endmodule

// File: tb/tb_bram_row_loader.sv
// Self-checking bench for bram_row_loader: scoreboarded BRAM writes plus a step table.
module tb_bram_row_loader;

  localparam int unsigned Hres  = 8;
  localparam int unsigned Vres  = 10;
  localparam int unsigned Win   = 7;
  localparam int unsigned Nrows = 8;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 13;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } exp_t;

  typedef struct {
    bit fin_pre;
    int n_pix;
    bit fin_last;
    bit exp_ready;
    bit exp_busy;
    int exp_fd;
  } step_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  bram_row_loader_if #(
    .BRAM_DATA_WIDTH (DW),
    .BRAM_ADDR_WIDTH (AW),
    .BRAM_WE_WIDTH   (1)
  ) bus ();

  bram_row_loader #(
    .NUM_OF_ROWS_IN_BRAM (Nrows),
    .VRES                (Vres),
    .HRES                (Hres),
    .WINDOW              (Win),
    .BRAM_DATA_WIDTH     (DW),
    .BRAM_ADDR_WIDTH     (AW),
    .BRAM_WE_WIDTH       (1)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  exp_t sb[$];
  int m_row = 0;
  int m_col = 0;
  int idx = 0;
  int cyc = 0;
  int n_wr = 0;
  int go_cnt = 0;
  int go_cyc = -1;
  int fd_cnt = 0;
  int wr55_cyc = -1;
  int wr15_cyc = -1;
  int fall_cyc = -1;
  logic busy_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push on handshake, pop on the write one cycle later.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (reset) begin
      sb.delete();
    end else begin
      if (bus.en) begin
        n_wr++;
        if (sb.size() == 0) begin
          chk("unexpected_write", 32'(bus.addr), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", 32'(bus.addr), 32'(e.addr));
          chk("wr_din", 32'(bus.din), 32'(e.din));
          chk("wr_we", 32'(bus.we), 32'd1);
        end
        if (bus.addr == AW'(55)) wr55_cyc = cyc;
        if (bus.addr == AW'(15)) wr15_cyc = cyc;
      end
      if (bus.go) begin
        go_cnt++;
        go_cyc = cyc;
      end
      if (bus.frame_done) fd_cnt++;
      if (busy_prev && !bus.busy) fall_cyc = cyc;
      if (bus.pix_valid && bus.pix_ready) begin
        e.addr = AW'((m_row % Nrows) * Hres + m_col);
        e.din  = bus.pix_data;
        sb.push_back(e);
        if (m_col == Hres - 1) begin
          m_col = 0;
          m_row++;
        end else begin
          m_col++;
        end
      end
    end
    busy_prev = bus.busy;
  end

  task automatic send_pix(input int n, input bit fin_last);
    int sent = 0;
    int guard = 0;
    bit hs;
    bus.pix_valid    = 1'b1;
    bus.pix_data     = DW'(idx);
    bus.finished_row = fin_last && (n == 1);
    while (sent < n && guard < 100) begin
      @(negedge clk);
      hs = bus.pix_ready;
      @(posedge clk);
      #1;
      if (hs) begin
        sent++;
        idx++;
        bus.pix_data     = DW'(idx);
        bus.finished_row = fin_last && (sent == n - 1);
      end else begin
        guard++;
      end
    end
    bus.pix_valid    = 1'b0;
    bus.finished_row = 1'b0;
    if (sent < n) chk("send_timeout", 32'(sent), 32'(n));
  endtask

  task automatic pulse_fin();
    bus.finished_row = 1'b1;
    @(posedge clk);
    #1;
    bus.finished_row = 1'b0;
  endtask

  task automatic start();
    m_row = 0;
    m_col = 0;
    bus.start_frame = 1'b1;
    @(posedge clk);
    #1;
    bus.start_frame = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(bus.pix_ready), 32'd0);
    chk({tag, "_en"}, 32'(bus.en), 32'd0);
    chk({tag, "_we"}, 32'(bus.we), 32'd0);
    chk({tag, "_addr"}, 32'(bus.addr), 32'd0);
    chk({tag, "_din"}, 32'(bus.din), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_go"}, 32'(bus.go), 32'd0);
    chk({tag, "_fdone"}, 32'(bus.frame_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step_t steps[7];
    // fin_pre, n_pix, fin_last, exp_ready, exp_busy, exp_fd
    steps[0] = '{1'b0, 56, 1'b0, 1'b1, 1'b0, 0};  // prime rows 0..6
    steps[1] = '{1'b0, 8,  1'b0, 1'b0, 1'b0, 0};  // row 7 fills the buffer
    steps[2] = '{1'b1, 8,  1'b1, 1'b1, 1'b0, 0};  // row 8; last pixel with finished_row
    steps[3] = '{1'b1, 0,  1'b0, 1'b1, 1'b1, 0};  // stall: row 9 missing
    steps[4] = '{1'b0, 8,  1'b0, 1'b0, 1'b0, 0};  // row 9 completes the frame input
    steps[5] = '{1'b1, 0,  1'b0, 1'b0, 1'b0, 1};  // 4th finished_row ends frame
    steps[6] = '{1'b1, 0,  1'b0, 1'b0, 1'b0, 1};  // 5th ignored

    bus.start_frame  = 1'b0;
    bus.pix_data     = '0;
    bus.pix_valid    = 1'b0;
    bus.finished_row = 1'b0;
    #1 reset = 1'b1;
    #2 chk_all_zero("rst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.pix_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ready", 32'(bus.pix_ready), 32'd0);
    end
    bus.pix_valid = 1'b0;
    @(posedge clk);
    #1;

    start();
    for (int s = 0; s < 7; s++) begin
      if (steps[s].fin_pre) pulse_fin();
      if (steps[s].n_pix > 0) send_pix(steps[s].n_pix, steps[s].fin_last);
      repeat (4) @(negedge clk);
      chk($sformatf("step%0d_ready", s), 32'(bus.pix_ready), 32'(steps[s].exp_ready));
      chk($sformatf("step%0d_busy", s), 32'(bus.busy), 32'(steps[s].exp_busy));
      chk($sformatf("step%0d_fdone", s), 32'(fd_cnt), 32'(steps[s].exp_fd));
      if (s == 0) begin
        chk("go_count", 32'(go_cnt), 32'd1);
        chk("go_after_wr55", 32'(go_cyc), 32'(wr55_cyc + 1));
        chk("busy_fall_at_go", 32'(fall_cyc), 32'(go_cyc));
      end
      if (s == 4) begin
        chk("busy_fall_after_wr15", 32'(fall_cyc), 32'(wr15_cyc + 1));
        chk("frame_writes", 32'(n_wr), 32'(Vres * Hres));
      end
      @(posedge clk);
      #1;
    end
    chk("go_count_frame", 32'(go_cnt), 32'd1);

    // New frame restarts at address 0, then a reset lands mid-stream.
    start();
    send_pix(3, 1'b0);
    bus.pix_valid = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("pre_reset_en", 32'(bus.en), 32'd1);
    reset = 1'b1;
    #1 chk_all_zero("mid_rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_ready", 32'(bus.pix_ready), 32'd0);
      chk("post_rst_en", 32'(bus.en), 32'd0);
    end
    bus.pix_valid = 1'b0;
    @(posedge clk);
    #1;

    start();
    send_pix(2, 1'b0);
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
